pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Owns the architectural PC register and sequences the next-PC mux (sequential/branch/J/JR).
//  Adds stall hold, a syscall HALT/resume state machine and performance counters.
//  Sits between the control unit / hazard logic and instruction memory address port.
// PARAMETERS
//  ADDR_BITS   32             width of PC and all address ports
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  IRQ_VECTOR  32'h0000_0800  handler entry PC (used only with PC_IRQ_EN)
// PORTS
//  clk           in   1          system clock, all state on rising edge
//  rst           in   1          synchronous reset, active-high
//  stall         in   1          hazard hold: PC and state frozen this cycle
//  halt          in   1          syscall halt request from decoded instruction
//  go            in   1          resume request (level) while halted
//  Jmp           in   1          J/JAL decoded
//  Jr            in   1          JR decoded
//  pcsel         in   1          conditional branch taken
//  imm_16        in   16         branch offset (words, signed)
//  imm_26        in   26         jump target index
//  regfile_out1  in   ADDR_BITS  JR target (rs value)
//  pc            out  ADDR_BITS  current PC (registered)
//  pc_plus4      out  ADDR_BITS  pc + 4 (combinational, for JAL link)
//  halted        out  1          1 when state == HALT
//  cycle_cnt     out  32         cycles spent outside HALT
//  redirect_cnt  out  32         committed non-sequential PC updates
// BEHAVIOUR
//  Reset (rst=1 at edge): pc=RESET_PC, state=RUN, halted=0, cycle_cnt=0, redirect_cnt=0.
//  Next-PC (all arithmetic mod 2^ADDR_BITS), priority Jr > Jmp > pcsel > sequential:
//   Jr    -> regfile_out1
//   Jmp   -> {pc_plus4[31:28], imm_26, 2'b00}
//   pcsel -> pc_plus4 + ({{14{imm_16[15]}}, imm_16} << 2)
//   else  -> pc_plus4
//  States: RUN, STALL, HALT (2-bit encoded).
//   RUN:   stall=1 -> STALL, pc held. halt=1 & stall=0 -> HALT, pc held on halting instr.
//          else pc<=next-PC, 1-cycle latency; redirect_cnt++ if Jr|Jmp|pcsel.
//   STALL: stall=1 -> stay, pc held. stall=0 -> same evaluation as RUN this cycle.
//   HALT:  pc held; all redirect inputs and stall ignored. go=1 -> RUN, pc<=pc_plus4.
//  halt asserted together with stall: halt ignored (instruction not yet valid).
//  Redirect inputs are evaluated only on an update cycle; never latched across stalls.
//  cycle_cnt increments every cycle state != HALT (incl. STALL); both counters wrap
//  32'hFFFF_FFFF -> 0 silently.
//  Reset mid-operation (any state, incl. HALT or STALL) wins over all other inputs.
// CONFIGURATION
//  PC_IRQ_EN defined: adds ports irq(in,1), eret(in,1), epc(out,ADDR_BITS) and
//   internal ie flag (reset ie=1, epc=0).
//   RUN/STALL update cycle with irq=1 & ie=1: epc<=computed next-PC,
//    pc<=IRQ_VECTOR, ie<=0, redirect_cnt++. irq has priority over Jr/Jmp/pcsel;
//    halt at the same cycle is dropped.
//   eret=1 on update cycle: pc<=epc, ie<=1, redirect_cnt++; eret beats Jr/Jmp/pcsel.
//   irq ignored in HALT.
//  PC_IRQ_EN undefined: ports/logic absent; behaviour exactly as above.
// TESTING
//  1 rst 1 cycle, then 3 idle cycles -> pc 0,4,8,12; cycle_cnt=3; redirect_cnt=0.
//  2 pc=4, pcsel=1, imm_16=16'h0001 -> pc=12; imm_16=16'hFFFF from pc=12 -> pc=12; redirect_cnt=2.
//  3 pc=4, Jmp=1, imm_26=26'h3FFFFFF -> pc=32'h0FFF_FFFC;
//    same cycle Jr=1, regfile_out1=4 -> pc=4 (Jr wins).
//  4 stall=1 for 3 cycles with Jmp=1 -> pc unchanged, state STALL, cycle_cnt+3;
//    release with Jmp=0 -> pc+4 (no stale jump).
//  5 halt=1 at pc=8 -> halted=1, pc=8 held for 5 cycles, cycle_cnt frozen;
//    go=1 -> pc=12, halted=0. Repeat with halt+stall -> no halt.
//  6 rst pulsed while halted and during stall -> pc=RESET_PC, state RUN, counters 0;
//    PC_IRQ_EN: irq at pc=8 -> pc=IRQ_VECTOR, epc=12; eret -> pc=12.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register and next-PC sequencing with stall hold, syscall HALT/resume and perf counters; PC_IRQ_EN adds irq/eret/epc.
module pc_sequencer #(
    parameter int ADDR_BITS = 32,
    parameter logic [ADDR_BITS-1:0] RESET_PC = '0
`ifdef PC_IRQ_EN
    ,
    parameter logic [ADDR_BITS-1:0] IRQ_VECTOR = ADDR_BITS'(32'h0000_0800)
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 halt,
    input  logic                 go,
`ifdef PC_IRQ_EN
    input  logic                 irq,
    input  logic                 eret,
    output logic [ADDR_BITS-1:0] epc,
`endif
    input  logic                 Jmp,
    input  logic                 Jr,
    input  logic                 pcsel,
    input  logic [15:0]          imm_16,
    input  logic [25:0]          imm_26,
    input  logic [ADDR_BITS-1:0] regfile_out1,
    output logic [ADDR_BITS-1:0] pc,
    output logic [ADDR_BITS-1:0] pc_plus4,
    output logic                 halted,
    output logic [31:0]          cycle_cnt,
    output logic [31:0]          redirect_cnt
);
    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;
    state_t state;
    logic [ADDR_BITS-1:0] jmp_target, br_target, next_pc;
    logic redirect;
`ifdef PC_IRQ_EN
    logic ie;
`endif
    assign pc_plus4   = pc + ADDR_BITS'(4);
    assign jmp_target = {pc_plus4[ADDR_BITS-1:28], imm_26, 2'b00};
    assign br_target  = pc_plus4 + ({{(ADDR_BITS-16){imm_16[15]}}, imm_16} << 2);
    assign next_pc    = Jr ? regfile_out1 : Jmp ? jmp_target : pcsel ? br_target : pc_plus4;
    assign redirect   = Jr | Jmp | pcsel;
    // STALL evaluates exactly like RUN once stall drops; HALT ignores everything but go
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            state        <= RUN;
            halted       <= 1'b0;
            cycle_cnt    <= '0;
            redirect_cnt <= '0;
`ifdef PC_IRQ_EN
            ie           <= 1'b1;
            epc          <= '0;
`endif
        end else begin
            if (state != HALT)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (state == HALT) begin
                if (go) begin
                    pc     <= pc_plus4;
                    state  <= RUN;
                    halted <= 1'b0;
                end
            end else if (stall) begin
                state <= STALL;
            end
`ifdef PC_IRQ_EN
            else if (irq && ie) begin
                epc          <= next_pc;
                pc           <= IRQ_VECTOR;
                ie           <= 1'b0;
                state        <= RUN;
                redirect_cnt <= redirect_cnt + 32'd1;
            end else if (eret) begin
                pc           <= epc;
                ie           <= 1'b1;
                state        <= RUN;
                redirect_cnt <= redirect_cnt + 32'd1;
            end
`endif
            else if (halt) begin
                state  <= HALT;
                halted <= 1'b1;
            end else begin
                pc    <= next_pc;
                state <= RUN;
                if (redirect)
                    redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end
endmodule
